memory_stage_pipe: RTL and testbench

- Memory stage of the 16-bit pipelined CPU, sitting between execute and writeback.
- Contains three parts:
  - the EX/MEM pipeline register (ExecuteMemory_register function);
  - a 1-to-2 result demultiplexer (decoderMemory function);
  - a word-addressed data RAM.
- A 2:1 result mux feeds the MEM/WB pipeline register (MemoryWriteback_register function).
- Pipeline-stage outputs are exposed for forwarding and writeback.

---
 rtl/memory_stage_pipe.sv | 117 +++++++++++
 tb/tb_memory_stage_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_pipe.sv
// Memory stage of the 16-bit pipelined CPU: EX/MEM register, result demux,
// word-addressed data RAM, result mux and MEM/WB register.
module memory_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_e,
  input  logic              wme_e,
  input  logic              mm_e,
  input  logic              wm_e,
  input  logic              ni_e,
  input  logic [DATA_W-1:0] alu_result_e,
  input  logic [DATA_W-1:0] write_data_e,
  output logic              wbs_m,
  output logic              wme_m,
  output logic              mm_m,
  output logic              wm_m,
  output logic              ni_m,
  output logic [DATA_W-1:0] alu_result_m,
  output logic [DATA_W-1:0] write_data_m,
  output logic [DATA_W-1:0] aux_data_m,
  output logic              wbs_w,
  output logic [DATA_W-1:0] mem_data_w,
  output logic [DATA_W-1:0] alu_result_w,
  output logic              ni_w
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              wbs_q, wme_q, mm_q, wm_q, ni_q;
  logic [DATA_W-1:0] alu_result_q, write_data_q;
  logic              wbs_w_q, ni_w_q;
  logic [DATA_W-1:0] mem_data_w_q, alu_result_w_q;

  logic [DATA_W-1:0] addr_path_s;
  logic [DATA_W-1:0] aux_data_s;
  logic [DATA_W-1:0] mux_out_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [ADDR_W-1:0] mem_addr_s;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // EX/MEM pipeline register: free-running capture of the execute outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_q        <= 1'b0;
      wme_q        <= 1'b0;
      mm_q         <= 1'b0;
      wm_q         <= 1'b0;
      ni_q         <= 1'b0;
      alu_result_q <= {DATA_W{1'b0}};
      write_data_q <= {DATA_W{1'b0}};
    end else begin
      wbs_q        <= wbs_e;
      wme_q        <= wme_e;
      mm_q         <= mm_e;
      wm_q         <= wm_e;
      ni_q         <= ni_e;
      alu_result_q <= alu_result_e;
      write_data_q <= write_data_e;
    end
  end

  // Demux of the ALU result; the unselected leg is forced to zero
  always_comb begin
    addr_path_s = {DATA_W{1'b0}};
    aux_data_s  = {DATA_W{1'b0}};
    if (mm_q) begin
      aux_data_s = alu_result_q;
    end else begin
      addr_path_s = alu_result_q;
    end
  end

  // Upper address bits are dropped so addresses wrap modulo the RAM depth
  assign mem_addr_s = addr_path_s[ADDR_W-1:0];
  assign rd_data_s  = mem_q[mem_addr_s];
  assign mux_out_s  = wm_q ? write_data_q : addr_path_s;

  // Data RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wme_q) begin
      mem_q[mem_addr_s] <= write_data_q;
    end
  end

  // MEM/WB pipeline register; a same-address store reads the old word here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_w_q        <= 1'b0;
      mem_data_w_q   <= {DATA_W{1'b0}};
      alu_result_w_q <= {DATA_W{1'b0}};
      ni_w_q         <= 1'b0;
    end else begin
      wbs_w_q        <= wbs_q;
      mem_data_w_q   <= rd_data_s;
      alu_result_w_q <= mux_out_s;
      ni_w_q         <= ni_q;
    end
  end

  assign wbs_m        = wbs_q;
  assign wme_m        = wme_q;
  assign mm_m         = mm_q;
  assign wm_m         = wm_q;
  assign ni_m         = ni_q;
  assign alu_result_m = alu_result_q;
  assign write_data_m = write_data_q;
  assign aux_data_m   = aux_data_s;
  assign wbs_w        = wbs_w_q;
  assign mem_data_w   = mem_data_w_q;
  assign alu_result_w = alu_result_w_q;
  assign ni_w         = ni_w_q;

endmodule

// File: tb/tb_memory_stage_pipe.sv
// Directed self-checking bench for memory_stage_pipe; inputs change 1 ns after
// each rising edge and outputs are checked at that same point.
module tb_memory_stage_pipe;

  logic        clk;
  logic        rst_n;
  logic        wbs_e, wme_e, mm_e, wm_e, ni_e;
  logic [15:0] alu_result_e, write_data_e;
  logic        wbs_m, wme_m, mm_m, wm_m, ni_m;
  logic [15:0] alu_result_m, write_data_m, aux_data_m;
  logic        wbs_w, ni_w;
  logic [15:0] mem_data_w, alu_result_w;

  int n_cmp;
  int n_fail;

  memory_stage_pipe #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_e(wbs_e), .wme_e(wme_e), .mm_e(mm_e), .wm_e(wm_e), .ni_e(ni_e),
    .alu_result_e(alu_result_e), .write_data_e(write_data_e),
    .wbs_m(wbs_m), .wme_m(wme_m), .mm_m(mm_m), .wm_m(wm_m), .ni_m(ni_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .aux_data_m(aux_data_m),
    .wbs_w(wbs_w), .mem_data_w(mem_data_w), .alu_result_w(alu_result_w),
    .ni_w(ni_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic wbs, input logic wme, input logic mm,
                        input logic wm, input logic ni,
                        input logic [15:0] alu, input logic [15:0] wd);
    wbs_e = wbs; wme_e = wme; mm_e = mm; wm_e = wm; ni_e = ni;
    alu_result_e = alu; write_data_e = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [71:0] flat;
    rst_n = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    #12;
    flat = {wbs_m, wme_m, mm_m, wm_m, ni_m, alu_result_m, write_data_m,
            wbs_w, mem_data_w, alu_result_w, ni_w};
    n_cmp++;
    if (flat !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want 0", flat);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({wbs_m, wme_m, mm_m, wm_m, ni_m} !== 5'b11111 ||
        alu_result_m !== 16'h0010 || write_data_m !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL reset_release_m: ctl=%b alu=%h wd=%h want 11111/0010/BEEF",
               {wbs_m, wme_m, mm_m, wm_m, ni_m}, alu_result_m, write_data_m);
    end
    step();
    n_cmp++;
    if (wbs_w !== 1'b1 || ni_w !== 1'b1 || alu_result_w !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL reset_release_w: wbs=%b ni=%b alu=%h want 1/1/BEEF",
               wbs_w, ni_w, alu_result_w);
    end
    #3 rst_n = 1'b0;
    #1;
    flat = {wbs_m, wme_m, mm_m, wm_m, ni_m, alu_result_m, write_data_m,
            wbs_w, mem_data_w, alu_result_w, ni_w};
    n_cmp++;
    if (flat !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want 0", flat);
    end
    step();
    flat = {wbs_m, wme_m, mm_m, wm_m, ni_m, alu_result_m, write_data_m,
            wbs_w, mem_data_w, alu_result_w, ni_w};
    n_cmp++;
    if (flat !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_held_over_edge: got %h want 0", flat);
    end
    #3 rst_n = 1'b1;
    // mm=1 store above went to address 0 and must survive the reset
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    step();
    n_cmp++;
    if (mem_data_w !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL ram_addr0_after_reset: got %h want BEEF", mem_data_w);
    end
  endtask

  task automatic test_pass_through();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFF00, 16'h00FF);
    step();
    n_cmp++;
    if (alu_result_m !== 16'hFF00 || aux_data_m !== 16'hFF00 ||
        write_data_m !== 16'h00FF || wm_m !== 1'b1 || ni_m !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_m: alu=%h aux=%h wd=%h wm=%b ni=%b want FF00/FF00/00FF/1/1",
               alu_result_m, aux_data_m, write_data_m, wm_m, ni_m);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    n_cmp++;
    if (alu_result_w !== 16'h00FF || wbs_w !== 1'b1 || ni_w !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_w: alu=%h wbs=%b ni=%b want 00FF/1/1",
               alu_result_w, wbs_w, ni_w);
    end
  endtask

  task automatic test_store_load();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00AA, 16'h5555);
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00AA, 16'h0000);
    step();
    n_cmp++;
    if (aux_data_m !== 16'h0000) begin
      n_fail++;
      $display("FAIL load_aux_zero: got %h want 0000", aux_data_m);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    n_cmp++;
    if (mem_data_w !== 16'h5555 || alu_result_w !== 16'h00AA) begin
      n_fail++;
      $display("FAIL store_load: mem=%h alu=%h want 5555/00AA",
               mem_data_w, alu_result_w);
    end
  endtask

  task automatic test_addr_wrap();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h01AA, 16'h1234);
    step();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00AA, 16'h0000);
    step();
    step();
    n_cmp++;
    if (mem_data_w !== 16'h1234) begin
      n_fail++;
      $display("FAIL addr_wrap: got %h want 1234", mem_data_w);
    end
  endtask

  task automatic test_read_during_write();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00AA, 16'h7777);
    step();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00AA, 16'h0000);
    step();
    n_cmp++;
    if (mem_data_w !== 16'h1234) begin
      n_fail++;
      $display("FAIL rdw_old: got %h want 1234", mem_data_w);
    end
    step();
    n_cmp++;
    if (mem_data_w !== 16'h7777) begin
      n_fail++;
      $display("FAIL rdw_new: got %h want 7777", mem_data_w);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] alu_v [3];
    logic [15:0] wd_v  [3];
    logic        wm_v  [3];
    logic [15:0] exp_w [3];
    alu_v = '{16'hA55A, 16'h1111, 16'h3333};
    wd_v  = '{16'h0F0F, 16'h2222, 16'h4444};
    wm_v  = '{1'b0, 1'b1, 1'b0};
    exp_w = '{16'hA55A, 16'h2222, 16'h3333};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set_in(1'b0, 1'b0, 1'b0, wm_v[i], 1'b0, alu_v[i], wd_v[i]);
      else       set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step();
      if (i < 3) begin
        n_cmp++;
        if (alu_result_m !== alu_v[i]) begin
          n_fail++;
          $display("FAIL b2b_m[%0d]: got %h want %h", i, alu_result_m, alu_v[i]);
        end
      end
      if (i > 0) begin
        n_cmp++;
        if (alu_result_w !== exp_w[i-1]) begin
          n_fail++;
          $display("FAIL b2b_w[%0d]: got %h want %h", i - 1, alu_result_w, exp_w[i-1]);
        end
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_pass_through();
    test_store_load();
    test_addr_wrap();
    test_read_during_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
